// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide controller.
// Covers the operand width, counter width, op codes and FSM state encoding.
package muldiv_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  typedef enum logic {
    OP_MULU = 1'b0,
    OP_DIVU = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_sub_64bit.sv
// 64-bit adder/subtractor. mode=0 computes a+b; mode=1 computes a-b.
// In subtract mode, carry_flag=1 means no borrow occurred.
module add_sub_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        mode,
  output logic [63:0] s,
  output logic        carry_flag,
  output logic        overflow_flag
);

  logic [63:0] b_eff;

  always_comb begin
    b_eff = mode ? ~b : b;
    {carry_flag, s} = {1'b0, a} + {1'b0, b_eff} + {64'd0, mode};
    overflow_flag = (a[63] == b_eff[63]) && (s[63] != a[63]);
  end

endmodule

// File: rtl/seq_muldiv_ctrl.sv
// Multi-cycle unsigned 64x64 MULU/DIVU sequencer.
// Performs one add or subtract per clock on a shared add_sub_64bit.
module seq_muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_hi,
  output logic [XLEN-1:0] out_lo,
  output logic            out_div0
);

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] cnt;
  // hi_q/lo_q hold acc_hi/acc_lo for MULU and rem/quo for DIVU;
  // b_q holds the multiplicand for MULU and the divisor for DIVU.
  logic [XLEN-1:0]  hi_q, lo_q, b_q;
  logic [XLEN-1:0]  nxt_hi, nxt_lo;

  logic [XLEN-1:0]  add_a, add_b, add_s;
  logic             add_mode, add_c, adder_ovf_unused;
  logic             div_msb;
  logic [XLEN-1:0]  div_rsh;

  add_sub_64bit u_add_sub (
    .a             (add_a),
    .b             (add_b),
    .mode          (add_mode),
    .s             (add_s),
    .carry_flag    (add_c),
    .overflow_flag (adder_ovf_unused)
  );

  always_comb begin
    div_msb  = hi_q[XLEN-1];
    div_rsh  = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    add_mode = 1'b0;
    add_a    = hi_q;
    add_b    = b_q;
    nxt_hi   = hi_q;
    nxt_lo   = lo_q;
    if (op_q == OP_DIVU) begin
      add_a    = div_rsh;
      add_mode = (state == ITER);
      // A set msb means the shifted remainder already exceeds any divisor.
      if (div_msb || add_c) begin
        nxt_hi = add_s;
        nxt_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = div_rsh;
        nxt_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      {nxt_hi, nxt_lo} = {add_c, add_s, lo_q[XLEN-1:1]};
    end else begin
      {nxt_hi, nxt_lo} = {1'b0, hi_q, lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_hi    <= '0;
      out_lo    <= '0;
      out_div0  <= 1'b0;
      cnt       <= '0;
      op_q      <= OP_MULU;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !abort) begin
            cnt      <= '0;
            op_q     <= op_e'(in_op);
            in_ready <= 1'b0;
            if ((op_e'(in_op) == OP_DIVU) && (in_b == '0)) begin
              out_hi    <= in_a;
              out_lo    <= '1;
              out_div0  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              hi_q  <= '0;
              lo_q  <= (op_e'(in_op) == OP_MULU) ? in_b : in_a;
              b_q   <= (op_e'(in_op) == OP_MULU) ? in_a : in_b;
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            hi_q <= nxt_hi;
            lo_q <= nxt_lo;
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN - 1)) begin
              out_hi    <= nxt_hi;
              out_lo    <= nxt_lo;
              out_div0  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_ctrl.sv
// Bench for seq_muldiv_ctrl: a timing/result model checked every cycle,
// plus directed operations with hand-computed literal results.
module tb_seq_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_hi, out_lo;
  logic        out_div0;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int lat;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  seq_muldiv_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .out_div0  (out_div0)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1 = computing, 2 = result held.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [63:0]  m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_div0 = 1'b0;
  logic [127:0] m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_hi    = '0;
      m_lo    = '0;
      m_div0  = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid && !abort) begin
          if (in_op && in_b == 64'd0) begin
            m_hi = in_a; m_lo = ONES; m_div0 = 1'b1; m_phase = 2;
          end else begin
            if (in_op) begin
              p_lo = in_a / in_b;
              p_hi = in_a % in_b;
            end else begin
              m_prod = {64'd0, in_a} * {64'd0, in_b};
              p_hi = m_prod[127:64];
              p_lo = m_prod[63:0];
            end
            m_left  = 64;
            m_phase = 1;
          end
        end
        1: if (abort) m_phase = 0;
           else begin
             m_left--;
             if (m_left == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_div0 = 1'b0; m_phase = 2;
             end
           end
        default: if (abort || out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",  in_ready,  m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      chk("out_hi",    out_hi,    m_hi);
      chk("out_lo",    out_lo,    m_lo);
      chk("out_div0",  out_div0,  m_div0);
    end
  end

  // Driver tasks: callers sit 1 time unit after a rising edge.
  task automatic issue(input logic op, input logic [63:0] a, input logic [63:0] b);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_edges, input int exp_lat);
    lat = -1;
    for (int i = 0; i <= max_edges; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk(name, lat, exp_lat);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_release", in_ready, 1'b1);
  endtask

  task automatic run_op(input string name, input logic op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] hi, input logic [63:0] lo);
    issue(op, a, b);
    wait_valid({name, "_lat"}, 80, 64);
    chk({name, "_hi"}, out_hi, hi);
    chk({name, "_lo"}, out_lo, lo);
    chk({name, "_div0"}, out_div0, 1'b0);
    release_result();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_lo", out_lo, 64'd0);

    run_op("mul_3x5", 1'b0, 64'd3, 64'd5, 64'd0, 64'd15);
    run_op("mul_ones", 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
    run_op("div_100_7", 1'b1, 64'd100, 64'd7, 64'd2, 64'd14);
    run_op("div_msb", 1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'd1, 64'd1);

    // Divide by zero goes valid on the accepting edge itself.
    issue(1'b1, 64'h1234, 64'd0);
    wait_valid("div0_lat", 4, 0);
    chk("div0_hi", out_hi, 64'h1234);
    chk("div0_lo", out_lo, ONES);
    chk("div0_flag", out_div0, 1'b1);
    release_result();
    run_op("mul_clear_div0", 1'b0, 64'h1_0000_0001, 64'hFFFF_FFFF, 64'd0, ONES);

    // Backpressure: result must hold while out_ready stays low.
    issue(1'b0, 64'd12345, 64'd67890);
    wait_valid("bp_lat", 80, 64);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_lo", out_lo, 64'd838102050);
    release_result();

    // Abort in IDLE blocks the accept.
    in_op = 1'b0; in_a = 64'd2; in_b = 64'd2; in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_in_ready", in_ready, 1'b1);
    repeat (70) @(posedge clk);
    #1 chk("idle_abort_no_valid", out_valid, 1'b0);

    // Abort at cnt=30: result discarded, old outputs kept.
    issue(1'b1, 64'd1000, 64'd3);
    repeat (30) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_kept_lo", out_lo, 64'd838102050);
    repeat (40) @(posedge clk);
    #1 chk("abort_no_valid", out_valid, 1'b0);

    // Reset at cnt=10 of the next op.
    issue(1'b0, 64'd9, 64'd9);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_lo", out_lo, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op("mul_6x7", 1'b0, 64'd6, 64'd7, 64'd0, 64'd42);

    // Abort while the result is held.
    issue(1'b1, 64'd100, 64'd7);
    wait_valid("done_abort_lat", 80, 64);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("done_abort_valid", out_valid, 1'b0);
    chk("done_abort_kept_lo", out_lo, 64'd14);
    chk("done_abort_kept_hi", out_hi, 64'd2);

    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
